// File: rtl/rf_queue.sv
// Register-file FIFO: show-ahead head data, occupancy flags, sticky overflow/underflow
// and a physical-address debug read port. All state updates on the rising clock edge.
module rf_queue #(
    parameter int unsigned DW       = 16,
    parameter int unsigned AW       = 4,
    parameter int unsigned AFULL_TH = 12
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_flush,
    input  logic          i_enq,
    input  logic [DW-1:0] i_din,
    input  logic          i_deq,
    output logic [DW-1:0] o_dout,
    output logic          o_empty,
    output logic          o_full,
    output logic          o_afull,
    output logic [AW:0]   o_count,
    output logic          o_ovf,
    output logic          o_udf,
    input  logic [AW-1:0] i_dbg_addr,
    output logic [DW-1:0] o_dbg_data
);

    localparam int unsigned DEPTH    = 1 << AW;
    localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);
    localparam logic [AW:0] AfullCnt = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] CntOne   = (AW+1)'(1);
    localparam logic [AW-1:0] PtrOne = AW'(1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    logic          r_ovf;
    logic          r_udf;

    logic          w_empty;
    logic          w_full;
    logic          w_deq_ok;
    logic          w_enq_ok;
    logic [AW:0]   w_count_nxt;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == DepthCnt);
    assign w_deq_ok = i_deq & ~w_empty;
    // A full queue can still take a write when a read frees a slot the same cycle.
    assign w_enq_ok = i_enq & (~w_full | w_deq_ok);

    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_enq_ok, w_deq_ok})
            2'b10:   w_count_nxt = r_count + CntOne;
            2'b01:   w_count_nxt = r_count - CntOne;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else if (i_flush) begin
            // Storage is deliberately left intact; only bookkeeping is cleared.
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (w_enq_ok) begin
                r_mem[r_tail] <= i_din;
                r_tail        <= r_tail + PtrOne;
            end
            if (w_deq_ok) begin
                r_head <= r_head + PtrOne;
            end
            r_count <= w_count_nxt;
            if (i_enq && !w_enq_ok) begin
                r_ovf <= 1'b1;
            end
            if (i_deq && w_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign o_dout     = r_mem[r_head];
    assign o_dbg_data = r_mem[i_dbg_addr];
    assign o_empty    = w_empty;
    assign o_full     = w_full;
    assign o_afull    = (r_count >= AfullCnt);
    assign o_count    = r_count;
    assign o_ovf      = r_ovf;
    assign o_udf      = r_udf;

endmodule

// File: tb/tb_rf_queue.sv
// Directed self-checking bench for rf_queue (DW=16, AW=4, AFULL_TH=12).
module tb_rf_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        enq;
    logic [15:0] din;
    logic        deq;
    logic [15:0] dout;
    logic        empty;
    logic        full;
    logic        afull;
    logic [4:0]  count;
    logic        ovf;
    logic        udf;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_checks = 0;
    int n_pass   = 0;

    rf_queue #(
        .DW       (16),
        .AW       (4),
        .AFULL_TH (12)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_flush    (flush),
        .i_enq      (enq),
        .i_din      (din),
        .i_deq      (deq),
        .o_dout     (dout),
        .o_empty    (empty),
        .o_full     (full),
        .o_afull    (afull),
        .o_count    (count),
        .o_ovf      (ovf),
        .o_udf      (udf),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if ({count, empty, full, afull, ovf, udf} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_flags: got cnt=%0d e=%b f=%b af=%b o=%b u=%b expected 0,1,0,0,0,0",
                     count, empty, full, afull, ovf, udf);
        else n_pass++;
        n_checks++;
        if (dout !== 16'h0) $display("FAIL reset_dout: got 0x%0h expected 0x0", dout);
        else n_pass++;
        for (int a = 0; a < 16; a++) begin
            dbg_addr = 4'(a);
            #1;
            n_checks++;
            if (dbg_data !== 16'h0) $display("FAIL reset_dbg[%0d]: got 0x%0h expected 0x0", a, dbg_data);
            else n_pass++;
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            enq = 1'b1;
            din = 16'h1000 + 16'(i);
            tick();
            n_checks++;
            if (count !== 5'(i + 1) || afull !== (i + 1 >= 12) || full !== (i == 15))
                $display("FAIL fill[%0d]: got cnt=%0d af=%b f=%b expected cnt=%0d af=%b f=%b",
                         i, count, afull, full, i + 1, (i + 1 >= 12), (i == 15));
            else n_pass++;
        end
        enq = 1'b0;
        for (int i = 0; i < 16; i++) begin
            deq = 1'b1;
            n_checks++;
            if (dout !== 16'h1000 + 16'(i))
                $display("FAIL drain_dout[%0d]: got 0x%0h expected 0x%0h", i, dout, 16'h1000 + 16'(i));
            else n_pass++;
            tick();
        end
        deq = 1'b0;
        n_checks++;
        if (empty !== 1'b1 || count !== 5'd0)
            $display("FAIL drain_empty: got e=%b cnt=%0d expected e=1 cnt=0", empty, count);
        else n_pass++;
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 10; i++) begin
                enq = 1'b1;
                din = 16'h2000 + 16'(r * 16'h1000) + 16'(i);
                tick();
            end
            enq = 1'b0;
            for (int i = 0; i < 10; i++) begin
                deq = 1'b1;
                n_checks++;
                if (dout !== 16'h2000 + 16'(r * 16'h1000) + 16'(i))
                    $display("FAIL wrap_dout[%0d][%0d]: got 0x%0h expected 0x%0h", r, i, dout,
                             16'h2000 + 16'(r * 16'h1000) + 16'(i));
                else n_pass++;
                tick();
            end
            deq = 1'b0;
        end
        enq = 1'b1;
        din = 16'hBEEF;
        tick();
        enq = 1'b0;
        dbg_addr = 4'd4;
        #1;
        chk("wrap_dbg4", 32'(dbg_data), 32'hBEEF);
        chk("wrap_dout", 32'(dout), 32'hBEEF);
        chk("wrap_count", 32'(count), 32'd1);
        deq = 1'b1;
        tick();
        deq = 1'b0;
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 16; i++) begin
            enq = 1'b1;
            din = (i == 0) ? 16'hA5A5 : 16'hB000 + 16'(i);
            tick();
        end
        chk("simul_full", 32'(full), 32'd1);
        chk("simul_head", 32'(dout), 32'hA5A5);
        enq = 1'b1;
        deq = 1'b1;
        din = 16'h5A5A;
        tick();
        enq = 1'b0;
        deq = 1'b0;
        chk("simul_count", 32'(count), 32'd16);
        chk("simul_ovf", 32'(ovf), 32'd0);
        chk("simul_dout", 32'(dout), 32'hB001);
        for (int i = 1; i <= 16; i++) begin
            deq = 1'b1;
            n_checks++;
            if (dout !== ((i == 16) ? 16'h5A5A : 16'hB000 + 16'(i)))
                $display("FAIL simul_drain[%0d]: got 0x%0h expected 0x%0h", i, dout,
                         (i == 16) ? 16'h5A5A : 16'hB000 + 16'(i));
            else n_pass++;
            tick();
        end
        deq = 1'b0;
        chk("simul_empty", 32'(empty), 32'd1);
    endtask

    task automatic test_errors();
        for (int i = 0; i < 16; i++) begin
            enq = 1'b1;
            din = 16'hC000 + 16'(i);
            tick();
        end
        din = 16'hDEAD;
        tick();
        enq = 1'b0;
        chk("ovf_flag", 32'(ovf), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        // tail == head when full, so an illegal write would land on the head entry
        chk("ovf_nowrite", 32'(dout), 32'hC000);
        deq = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        chk("ovf_sticky", 32'(ovf), 32'd1);
        chk("udf_pre", 32'(udf), 32'd0);
        enq = 1'b1;
        din = 16'h7777;
        tick();
        enq = 1'b0;
        deq = 1'b0;
        chk("udf_flag", 32'(udf), 32'd1);
        chk("udf_count", 32'(count), 32'd1);
        chk("udf_dout", 32'(dout), 32'h7777);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_flags", 32'({ovf, udf}), 32'd0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
    endtask

    task automatic test_flush_rst();
        for (int i = 0; i < 5; i++) begin
            enq = 1'b1;
            din = 16'hE000 + 16'(i);
            tick();
        end
        chk("fr_count5", 32'(count), 32'd5);
        din = 16'hFFFF;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        enq = 1'b0;
        chk("fr_flush_count", 32'(count), 32'd0);
        dbg_addr = 4'd5;
        #1;
        chk("fr_flush_nowrite", 32'(dbg_data), 32'hC00F);
        enq = 1'b1;
        din = 16'h4444;
        tick();
        tick();
        din = 16'h1234;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        enq = 1'b0;
        chk("fr_rst_count", 32'(count), 32'd0);
        chk("fr_rst_empty", 32'(empty), 32'd1);
        dbg_addr = 4'd0;
        #1;
        chk("fr_rst_entry0", 32'(dbg_data), 32'd0);
        chk("fr_rst_dout", 32'(dout), 32'd0);
    endtask

    initial begin
        rst      = 1'b0;
        flush    = 1'b0;
        enq      = 1'b0;
        deq      = 1'b0;
        din      = '0;
        dbg_addr = '0;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_simul();
        test_errors();
        test_flush_rst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
